wr_pntrs_full_afull_sync: RTL and testbench

// - Write-domain pointer/flag block for the dual-clock FIFO, successor of the plain wr pointer/full block.
// - Generates binary write address, Gray write pointer for the read domain, full, almost-full and used-words.
// - Contains its own N-stage synchronizer for the incoming read Gray pointer.
// - Instantiated in the FIFO top between the write port and the DPRAM write side.

---
 rtl/wr_pntrs_full_afull_sync.sv | 86 ++++++++
 tb/tb_wr_pntrs_full_afull_sync.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wr_pntrs_full_afull_sync.sv
// Write-side pointer/flag block of the dual-clock FIFO: binary RAM address, Gray pointer, full,
// almost-full and used-words, with its own read-pointer synchronizer. WR_PNTRS_OVF_EN adds a sticky overflow flag.
module wr_pntrs_full_afull_sync #(
  parameter int AWIDTH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = 12
) (
  input  logic              wr_clk_i,
  input  logic              aclr_i,
  input  logic              wr_req_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_pntr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
  output logic              wr_full_o,
  output logic              wr_almost_full_o,
  output logic [AWIDTH:0]   wr_usedw_o,
  output logic              wr_ovf_o
);

  localparam logic [AWIDTH:0] AFULL_W = (AWIDTH+1)'(AFULL_LVL);

  logic [AWIDTH:0] wbin;
  logic [AWIDTH:0] wbin_next;
  logic [AWIDTH:0] wgray_next;
  logic [AWIDTH:0] rgray_s;
  logic [AWIDTH:0] rbin_s;
  logic [AWIDTH:0] used_next;
  logic [AWIDTH:0] full_gray;
  logic [AWIDTH:0] sync_q [SYNC_STAGES];

  // Gated by reset so nothing reaches the RAM while the block is being cleared.
  assign wr_en_o    = wr_req_i & ~wr_full_o & aclr_i;
  assign wbin_next  = wbin + {{AWIDTH{1'b0}}, wr_en_o};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign wr_pntr_o  = wbin[AWIDTH-1:0];

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_pntr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rgray_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AWIDTH; i++) rbin_s[i] = ^(rgray_s >> i);
  end

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_gray = {~rgray_s[AWIDTH:AWIDTH-1], rgray_s[AWIDTH-2:0]};
  assign used_next = wbin_next - rbin_s;

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      wbin             <= '0;
      wr_pntr_gray_o   <= '0;
      wr_full_o        <= 1'b0;
      wr_almost_full_o <= 1'b0;
      wr_usedw_o       <= '0;
    end else begin
      wbin             <= wbin_next;
      wr_pntr_gray_o   <= wgray_next;
      wr_full_o        <= (wgray_next == full_gray);
      wr_almost_full_o <= (used_next >= AFULL_W);
      wr_usedw_o       <= used_next;
    end
  end

`ifdef WR_PNTRS_OVF_EN
  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      wr_ovf_o <= 1'b0;
    end else if (wr_req_i & wr_full_o) begin
      wr_ovf_o <= 1'b1;
    end
  end
`else
  assign wr_ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_wr_pntrs_full_afull_sync.sv
// Scoreboard bench for wr_pntrs_full_afull_sync (AWIDTH=4, SYNC_STAGES=2, AFULL_LVL=12).
module tb_wr_pntrs_full_afull_sync;

  logic       wr_clk_i = 1'b0;
  logic       aclr_i;
  logic       wr_req_i;
  logic [4:0] rd_pntr_gray_i;
  logic       wr_en_o;
  logic [3:0] wr_pntr_o;
  logic [4:0] wr_pntr_gray_o;
  logic       wr_full_o;
  logic       wr_almost_full_o;
  logic [4:0] wr_usedw_o;
  logic       wr_ovf_o;

  wr_pntrs_full_afull_sync #(.AWIDTH(4), .SYNC_STAGES(2), .AFULL_LVL(12)) dut (
    .wr_clk_i         (wr_clk_i),
    .aclr_i           (aclr_i),
    .wr_req_i         (wr_req_i),
    .rd_pntr_gray_i   (rd_pntr_gray_i),
    .wr_en_o          (wr_en_o),
    .wr_pntr_o        (wr_pntr_o),
    .wr_pntr_gray_o   (wr_pntr_gray_o),
    .wr_full_o        (wr_full_o),
    .wr_almost_full_o (wr_almost_full_o),
    .wr_usedw_o       (wr_usedw_o),
    .wr_ovf_o         (wr_ovf_o)
  );

  always #5 wr_clk_i = ~wr_clk_i;

  typedef struct {
    logic [3:0] pntr;
    logic [4:0] gray;
    logic       full;
    logic       afull;
    logic [4:0] used;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: unbounded write count, read counts held in the two sync stages.
  int   m_wcnt;
  int   m_s0;
  int   m_s1;
  logic m_full;
  logic m_ovf;
  logic [4:0] prev_gray;

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_s0 = 0; m_s1 = 0; m_full = 1'b0; m_ovf = 1'b0;
    prev_gray = '0;
    sbq.delete();
  endtask

  // Called at a negedge: drive, predict the next posedge, then compare at the following negedge.
  task automatic step(input logic req, input int rdcnt);
    exp_t e;
    exp_t o;
    int   used;
    logic en;
    wr_req_i       = req;
    rd_pntr_gray_i = g5(rdcnt);
    #1;
    en = req & ~m_full;
    chk("wr_en", wr_en_o, en);
`ifdef WR_PNTRS_OVF_EN
    m_ovf = m_ovf | (req & m_full);
`endif
    m_wcnt = m_wcnt + en;
    used   = (m_wcnt - m_s1) & 31;
    m_s1   = m_s0;
    m_s0   = rdcnt;
    m_full = (used == 16);
    e.pntr  = m_wcnt[3:0];
    e.gray  = g5(m_wcnt);
    e.full  = m_full;
    e.afull = (used >= 12);
    e.used  = used[4:0];
    e.ovf   = m_ovf;
    sbq.push_back(e);
    @(posedge wr_clk_i);
    @(negedge wr_clk_i);
    o = sbq.pop_front();
    chk("wr_pntr",   wr_pntr_o,        o.pntr);
    chk("wr_gray",   wr_pntr_gray_o,   o.gray);
    chk("wr_full",   wr_full_o,        o.full);
    chk("wr_afull",  wr_almost_full_o, o.afull);
    chk("wr_usedw",  wr_usedw_o,       o.used);
    chk("wr_ovf",    wr_ovf_o,         o.ovf);
    chk("gray_ham",  ($countones(wr_pntr_gray_o ^ prev_gray) <= 1), 1);
    prev_gray = wr_pntr_gray_o;
  endtask

  // Asynchronous pulse between edges, with a write request pending.
  task automatic reset_pulse();
    wr_req_i       = 1'b1;
    rd_pntr_gray_i = '0;
    #1 aclr_i = 1'b0;
    #1;
    chk("rst_en",    wr_en_o,          0);
    chk("rst_pntr",  wr_pntr_o,        0);
    chk("rst_gray",  wr_pntr_gray_o,   0);
    chk("rst_full",  wr_full_o,        0);
    chk("rst_afull", wr_almost_full_o, 0);
    chk("rst_usedw", wr_usedw_o,       0);
    chk("rst_ovf",   wr_ovf_o,         0);
    #1 aclr_i = 1'b1;
    model_reset();
  endtask

  initial begin
    int rd;
    aclr_i         = 1'b0;
    wr_req_i       = 1'b0;
    rd_pntr_gray_i = '0;
    model_reset();
    repeat (2) @(negedge wr_clk_i);
    aclr_i = 1'b1;
    #1;
    chk("init_pntr",  wr_pntr_o,        0);
    chk("init_usedw", wr_usedw_o,       0);
    chk("init_full",  wr_full_o,        0);
    @(negedge wr_clk_i);

    // Reset mid-operation; a stale read pointer in the synchronizer must be cleared too.
    repeat (5) step(1'b1, 0);
    repeat (3) step(1'b0, 3);
    reset_pulse();
    step(1'b1, 0);

    // Fill from empty, then push against full.
    reset_pulse();
    repeat (16) step(1'b1, 0);
    repeat (3) step(1'b1, 0);
    chk("ovf_hold_gray", wr_pntr_gray_o, 5'b11000);

    // Drain: each read step lands three clocks later.
    repeat (3) step(1'b0, 4);
    repeat (3) step(1'b0, 5);
    step(1'b1, 5);

    // Continuous writes with reads trailing by three, across the pointer MSB wrap.
    reset_pulse();
    for (int i = 0; i < 40; i++) begin
      rd = (m_wcnt >= 3) ? m_wcnt - 3 : 0;
      step(1'b1, rd);
      chk("usedw_nz", (wr_usedw_o != 0), 1);
    end
    repeat (4) step(1'b0, m_wcnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
